rs_issue_queue: RTL

- Parametrised in-order reservation-station queue for the Tomasulo core; successor to the single-operand 3-entry functional-unit queue.
- Holds up to DEPTH instructions, each with two source operands, an op code and a unique destination ID.
- Snoops the common data bus (CDB) to resolve operand tags.
- Issues the head entry to its functional unit when both operands are ready and the unit accepts.

---
 rtl/rs_issue_queue_pkg.sv | 12 +
 rtl/rs_id_alloc.sv | 53 +++++
 rtl/rs_issue_queue.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rs_issue_queue_pkg.sv
// Shared widths and tag/ID constants for the reservation-station issue queues.
// Each functional unit queue owns a disjoint destination-ID range.
package rs_issue_queue_pkg;
    localparam int DW_DEF    = 32;
    localparam int TW_DEF    = 5;
    localparam int OPW_DEF   = 2;
    localparam int DEPTH_DEF = 4;
    localparam int TAG_READY = 0;

    localparam int ID_BASE_ADDSUB = 1;
    localparam int ID_BASE_MULDIV = 9;
endpackage

// File: rtl/rs_id_alloc.sv
// Destination-ID free-map with lowest-free priority encoder.
// An ID being freed this cycle is already visible as available.
module rs_id_alloc
    import rs_issue_queue_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TW      = TW_DEF,
    parameter int ID_BASE = ID_BASE_ADDSUB
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          flush,
    input  logic          alloc,
    input  logic          free_en,
    input  logic [TW-1:0] free_id,
    output logic [TW-1:0] alloc_id,
    output logic          any_free
);
    logic [DEPTH-1:0] free_map;
    logic [DEPTH-1:0] avail;
    logic [DEPTH-1:0] alloc_oh;

    always_comb begin
        avail = free_map;
        for (int i = 0; i < DEPTH; i++)
            if (free_en && free_id == TW'(ID_BASE + i))
                avail[i] = 1'b1;
    end

    always_comb begin
        alloc_id = TW'(ID_BASE);
        alloc_oh = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (avail[i]) begin
                alloc_id = TW'(ID_BASE + i);
                alloc_oh = DEPTH'(1) << i;
            end
        end
    end

    assign any_free = |avail;

    always_ff @(posedge clk or posedge RST) begin
        if (RST)
            free_map <= '1;
        else if (flush)
            free_map <= '1;
        else if (alloc)
            free_map <= avail & ~alloc_oh;
        else
            free_map <= avail;
    end
endmodule

// File: rtl/rs_issue_queue.sv
// In-order reservation-station queue: compacting shift storage, CDB snoop,
// head issues when both operands are ready and the functional unit accepts.
module rs_issue_queue
    import rs_issue_queue_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int DW      = DW_DEF,
    parameter int TW      = TW_DEF,
    parameter int OPW     = OPW_DEF,
    parameter int ID_BASE = ID_BASE_ADDSUB
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [OPW-1:0]             enq_op,
    input  logic [TW-1:0]              enq_tag1,
    input  logic [TW-1:0]              enq_tag2,
    input  logic [DW-1:0]              enq_val1,
    input  logic [DW-1:0]              enq_val2,
    output logic [TW-1:0]              enq_id,
    input  logic                       bc_valid,
    input  logic [TW-1:0]              bc_tag,
    input  logic [DW-1:0]              bc_data,
    input  logic                       fu_ready,
    output logic                       iss_valid,
    output logic [OPW-1:0]             iss_op,
    output logic [DW-1:0]              iss_val1,
    output logic [DW-1:0]              iss_val2,
    output logic [TW-1:0]              iss_id,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);

    function automatic logic snoop_hit(input logic v, input logic [TW-1:0] btag,
                                       input logic [TW-1:0] tag);
        return v && (btag != TW'(TAG_READY)) && (tag == btag);
    endfunction

    logic [DEPTH-1:0] busy;
    logic [OPW-1:0]   op   [DEPTH];
    logic [TW-1:0]    tag1 [DEPTH];
    logic [TW-1:0]    tag2 [DEPTH];
    logic [DW-1:0]    val1 [DEPTH];
    logic [DW-1:0]    val2 [DEPTH];
    logic [TW-1:0]    id   [DEPTH];

    logic          issue, enq_fire, any_free;
    logic [CW-1:0] wr_idx;
    logic          hit_e1, hit_e2;
    logic [TW-1:0] new_tag1, new_tag2;
    logic [DW-1:0] new_val1, new_val2;

    assign iss_valid = busy[0] && (tag1[0] == TW'(TAG_READY)) && (tag2[0] == TW'(TAG_READY));
    assign iss_op    = busy[0] ? op[0]   : '0;
    assign iss_val1  = busy[0] ? val1[0] : '0;
    assign iss_val2  = busy[0] ? val2[0] : '0;
    assign iss_id    = busy[0] ? id[0]   : '0;

    assign issue = iss_valid && fu_ready && !flush;
    // The free-map already counts the issuing head's ID, so any_free equals count<DEPTH || issue.
    assign enq_ready = !flush && any_free;
    assign enq_fire  = enq_valid && enq_ready;
    assign wr_idx    = issue ? count - CW'(1) : count;

    assign hit_e1   = snoop_hit(bc_valid, bc_tag, enq_tag1);
    assign hit_e2   = snoop_hit(bc_valid, bc_tag, enq_tag2);
    assign new_tag1 = hit_e1 ? '0 : enq_tag1;
    assign new_tag2 = hit_e2 ? '0 : enq_tag2;
    assign new_val1 = hit_e1 ? bc_data : enq_val1;
    assign new_val2 = hit_e2 ? bc_data : enq_val2;

    rs_id_alloc #(.DEPTH(DEPTH), .TW(TW), .ID_BASE(ID_BASE)) u_alloc (
        .clk      (clk),
        .RST      (RST),
        .flush    (flush),
        .alloc    (enq_fire),
        .free_en  (issue),
        .free_id  (id[0]),
        .alloc_id (enq_id),
        .any_free (any_free)
    );

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic           busy_q, s_busy, load, h1, h2;
        logic [OPW-1:0] op_q, s_op;
        logic [TW-1:0]  tag1_q, tag2_q, id_q, s_t1, s_t2, s_id;
        logic [DW-1:0]  val1_q, val2_q, s_v1, s_v2;

        assign busy[i] = busy_q;
        assign op[i]   = op_q;
        assign tag1[i] = tag1_q;
        assign tag2[i] = tag2_q;
        assign val1[i] = val1_q;
        assign val2[i] = val2_q;
        assign id[i]   = id_q;

        // Source of this slot's next state: itself, or its upstream neighbour on issue.
        if (i == DEPTH - 1) begin : g_last
            always_comb begin
                s_busy = busy[i] && !issue;
                s_op = op[i];  s_t1 = tag1[i]; s_t2 = tag2[i];
                s_v1 = val1[i]; s_v2 = val2[i]; s_id = id[i];
            end
        end else begin : g_mid
            always_comb begin
                s_busy = issue ? busy[i+1] : busy[i];
                s_op   = issue ? op[i+1]   : op[i];
                s_t1   = issue ? tag1[i+1] : tag1[i];
                s_t2   = issue ? tag2[i+1] : tag2[i];
                s_v1   = issue ? val1[i+1] : val1[i];
                s_v2   = issue ? val2[i+1] : val2[i];
                s_id   = issue ? id[i+1]   : id[i];
            end
        end

        assign load = enq_fire && (wr_idx == CW'(i));
        assign h1   = snoop_hit(bc_valid, bc_tag, s_t1);
        assign h2   = snoop_hit(bc_valid, bc_tag, s_t2);

        always_ff @(posedge clk or posedge RST) begin
            if (RST)
                busy_q <= 1'b0;
            else if (flush)
                busy_q <= 1'b0;
            else
                busy_q <= s_busy || load;
        end

        always_ff @(posedge clk) begin
            if (load) begin
                op_q   <= enq_op;
                tag1_q <= new_tag1;
                tag2_q <= new_tag2;
                val1_q <= new_val1;
                val2_q <= new_val2;
                id_q   <= enq_id;
            end else begin
                op_q   <= s_op;
                tag1_q <= h1 ? '0 : s_t1;
                tag2_q <= h2 ? '0 : s_t2;
                val1_q <= h1 ? bc_data : s_v1;
                val2_q <= h2 ? bc_data : s_v2;
                id_q   <= s_id;
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST)
            count <= '0;
        else if (flush)
            count <= '0;
        else if (enq_fire && !issue)
            count <= count + CW'(1);
        else if (issue && !enq_fire)
            count <= count - CW'(1);
    end
endmodule
